// File: rtl/conv_layer_core.sv
// rtl/conv_layer_core.sv - six-channel 3x3 convolution engine over a ROM-resident image
`ifndef EXT_ADDR_WIDTH
`define EXT_ADDR_WIDTH 8
`endif

module conv_layer_core #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [31:0]                data_in,
    output logic [`EXT_ADDR_WIDTH-1:0] rom_addr,
    output logic [191:0]               o_pixel_bus,
    output logic                       o_valid,
    output logic                       o_done
);
    localparam int AW = `EXT_ADDR_WIDTH;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic          capture;
    logic          win_valid;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [31:0]   lb0 [IMG_W];
    logic [31:0]   lb1 [IMG_W];
    logic [31:0]   win [3][3];
    logic [31:0]   k0, k1, k2, k3, k4, k5;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE:  if (enable) state_nxt = RUN;
            RUN: begin
                if (enable) begin
                    capture = 1'b1;
                    if (rom_addr == LAST_ADDR) state_nxt = DRAIN;
                end
            end
            DRAIN: state_nxt = DONE;
            DONE:  o_done = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // row/col track the pixel being captured so validity needs no divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            win_valid <= capture && (row >= RW'(2)) && (col >= CW'(2));
            if (capture && rom_addr != LAST_ADDR) begin
                rom_addr <= rom_addr + 1'b1;
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffers are IMG_W-deep shift registers: their tails are the pixels
    // one and two rows above the incoming one, in the same column.
    always_ff @(posedge clk) begin
        if (capture) begin
            lb1[0] <= data_in;
            lb0[0] <= lb1[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb1[i] <= lb1[i-1];
                lb0[i] <= lb0[i-1];
            end
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb0[IMG_W-1];
            win[1][2] <= lb1[IMG_W-1];
            win[2][2] <= data_in;
        end
    end

    // Two's complement wrap makes unsigned 32-bit adds exact for signed data
    always_comb begin
        k0 = win[1][1];
        k1 = win[0][0] + win[0][1] + win[0][2]
           + win[1][0] + win[1][1] + win[1][2]
           + win[2][0] + win[2][1] + win[2][2];
        k2 = (win[0][2] + (win[1][2] << 1) + win[2][2])
           - (win[0][0] + (win[1][0] << 1) + win[2][0]);
        k3 = (win[2][0] + (win[2][1] << 1) + win[2][2])
           - (win[0][0] + (win[0][1] << 1) + win[0][2]);
        k4 = (win[0][1] + win[1][0] + win[1][2] + win[2][1]) - (win[1][1] << 2);
        k5 = k1 << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid     <= 1'b0;
            o_pixel_bus <= '0;
        end else begin
            o_valid <= win_valid;
            if (win_valid) o_pixel_bus <= {k0, k1, k2, k3, k4, k5};
        end
    end
endmodule

// File: tb/tb_conv_layer_core.sv
// tb/tb_conv_layer_core.sv - scoreboard bench for conv_layer_core
module tb_conv_layer_core;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [31:0]  data_in;
    logic [7:0]   rom_addr;
    logic [191:0] o_pixel_bus;
    logic         o_valid;
    logic         o_done;

    logic [31:0]  mem [256];
    logic [191:0] sb [$];
    logic [191:0] first_bus, second_bus, last_bus;
    int           checks, errors, valid_cnt;

    conv_layer_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .data_in     (data_in),
        .rom_addr    (rom_addr),
        .o_pixel_bus (o_pixel_bus),
        .o_valid     (o_valid),
        .o_done      (o_done)
    );

    assign data_in = mem[rom_addr];
    always #5 clk = ~clk;

    task automatic chk(input logic [191:0] obs, input logic [191:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] expect_at(input int a);
        logic [31:0] p [3][3];
        logic [31:0] ch [6];
        int r, c;
        r = a / 16;
        c = a % 16;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = mem[(r - 2 + i) * 16 + (c - 2 + j)];
        ch[0] = p[1][1];
        ch[1] = 0;
        ch[5] = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ch[1] += p[i][j];
                ch[5] += 2 * p[i][j];
            end
        ch[2] = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        ch[3] = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        ch[4] = p[0][1] + p[1][0] + p[1][2] + p[2][1] - 4 * p[1][1];
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5]};
    endfunction

    task automatic load_expect();
        sb.delete();
        valid_cnt = 0;
        for (int a = 0; a < 256; a++)
            if (a / 16 >= 2 && a % 16 >= 2) sb.push_back(expect_at(a));
    endtask

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            valid_cnt++;
            if (valid_cnt == 1) first_bus = o_pixel_bus;
            if (valid_cnt == 2) second_bus = o_pixel_bus;
            last_bus = o_pixel_bus;
            chk(192'(sb.size() > 0), 192'd1, "sb_nonempty");
            if (sb.size() > 0) chk(o_pixel_bus, sb.pop_front(), "pixel_bus");
        end
    end

    // Cycle-accurate model of address sequencing, o_valid latency and o_done
    task automatic run_frame(input int pause_at, input int abort_at);
        int addr = 0, st = 0, paused = 0, after = 0;
        bit p0 = 0, p1 = 0, cap, finished = 0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            chk(192'(o_valid), 192'(p1), "o_valid_timing");
            if (st == 1) chk(192'(rom_addr), 192'(addr), "rom_addr");
            if (st == 2) begin
                after++;
                chk(192'(o_done), 192'(after >= 2), "o_done_timing");
                if (after == 2) finished = 1;
            end
            if (st == 1 && addr == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk(192'(rom_addr), 192'd0, "abort_rom_addr");
                chk(o_pixel_bus, 192'd0, "abort_bus");
                chk(192'(o_valid), 192'd0, "abort_valid");
                chk(192'(o_done), 192'd0, "abort_done");
                enable = 1'b0;
                sb.delete();
                finished = 1;
            end else if (!finished) begin
                enable = !(st == 1 && addr == pause_at && paused < 5);
                if (!enable) paused++;
                cap = (st == 1) && enable;
                p1 = p0;
                p0 = cap && (addr / 16 >= 2) && (addr % 16 >= 2);
                if (st == 0) st = 1;
                else if (cap) begin
                    if (addr == 255) st = 2;
                    else addr++;
                end
            end
        end
        chk(192'(finished), 192'd1, "frame_finished");
    endtask

    task automatic post_frame();
        repeat (3) begin
            @(negedge clk);
            chk(192'(rom_addr), 192'd255, "done_rom_addr");
            chk(192'(o_done), 192'd1, "done_sticky");
        end
        chk(192'(valid_cnt), 192'd196, "valid_count");
        chk(192'(sb.size()), 192'd0, "sb_drained");
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 32'(a);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk(192'(rom_addr), 192'd0, "reset_rom_addr");
        chk(o_pixel_bus, 192'd0, "reset_bus");
        chk(192'(o_valid), 192'd0, "reset_valid");
        chk(192'(o_done), 192'd0, "reset_done");
        rst_n = 1'b1;

        load_expect();
        run_frame(-1, -1);
        post_frame();
        chk(first_bus, {32'd17, 32'd153, 32'd8, 32'd128, 32'd0, 32'd306}, "ramp_first");
        chk(last_bus, {32'd238, 32'd2142, 32'd8, 32'd128, 32'd0, 32'd4284}, "ramp_last");

        do_reset();
        load_expect();
        run_frame(100, -1);
        post_frame();
        chk(last_bus, {32'd238, 32'd2142, 32'd8, 32'd128, 32'd0, 32'd4284}, "pause_last");

        do_reset();
        load_expect();
        run_frame(-1, 150);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_expect();
        run_frame(-1, -1);
        post_frame();
        chk(first_bus, {32'd17, 32'd153, 32'd8, 32'd128, 32'd0, 32'd306}, "restart_first");

        for (int a = 0; a < 256; a++) mem[a] = 32'h8000_0000;
        do_reset();
        load_expect();
        run_frame(-1, -1);
        post_frame();
        chk(last_bus, {32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0}, "wrap_last");

        for (int a = 0; a < 256; a++)
            mem[a] = ((a / 16 + a % 16) % 2 == 0) ? 32'd1 : 32'hFFFF_FFFF;
        do_reset();
        load_expect();
        run_frame(-1, -1);
        post_frame();
        chk(first_bus, {32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'd2}, "checker_plus");
        chk(second_bus, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFE},
            "checker_minus");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
